// File: rtl/elixirchip_es1_spu_op_bit_gather.sv
// Serial-to-parallel bit gatherer: collects single bits into a DATA_BITS word
// and emits it with a one-cycle strobe on the full count or an early s_last.
module elixirchip_es1_spu_op_bit_gather #(
  parameter int    DATA_BITS  = 36,
  parameter string LSB_FIRST  = "true",
  parameter logic  CLEAR_DATA = 1'b0,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cke,
  input  logic                           s_data,
  input  logic                           s_clear,
  input  logic                           s_valid,
  input  logic                           s_last,
  output logic [DATA_BITS-1:0]           m_data,
  output logic [$clog2(DATA_BITS+1)-1:0] m_count,
  output logic                           m_valid
);

  localparam int CW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int MW  = $clog2(DATA_BITS + 1);
  localparam bit LSB = (LSB_FIRST == "true");

  // Target/debug flags carry no behaviour.
  if (DEVICE == "" && SIMULATION == "" && DEBUG == "") begin : g_flags
  end

  logic [CW-1:0]        cnt;
  logic [DATA_BITS-1:0] asm_q;
  logic [DATA_BITS-1:0] nxt;
  logic [CW-1:0]        idx;
  logic                 done;

  always_comb begin
    idx = LSB ? cnt : (CW'(DATA_BITS - 1) - cnt);
    nxt = asm_q;
    nxt[idx] = s_data;
    done = (cnt == CW'(DATA_BITS - 1)) || s_last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      asm_q   <= '0;
      m_data  <= '0;
      m_count <= '0;
      m_valid <= 1'b0;
    end else if (cke) begin
      if (s_clear) begin
        cnt     <= '0;
        asm_q   <= '0;
        m_data  <= {DATA_BITS{CLEAR_DATA}};
        m_count <= '0;
        m_valid <= 1'b0;
      end else if (s_valid) begin
        if (done) begin
          // asm_q only holds filled positions, so the rest stay zero.
          m_data  <= nxt;
          m_count <= MW'(cnt) + MW'(1);
          m_valid <= 1'b1;
          cnt     <= '0;
          asm_q   <= '0;
        end else begin
          cnt     <= cnt + CW'(1);
          asm_q   <= nxt;
          m_valid <= 1'b0;
        end
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_bit_gather.sv
// Bench for the bit gatherer: three instances (8 LSB-first, 8 MSB-first,
// 1-bit) share stimulus and are compared against a queue-based model.
module tb_elixirchip_es1_spu_op_bit_gather;

  logic clk = 1'b0;
  logic rst_n, cke, s_data, s_clear, s_valid, s_last;
  logic [7:0] a_data, b_data;
  logic [3:0] a_cnt, b_cnt;
  logic a_val, b_val;
  logic [0:0] c_data, c_cnt;
  logic c_val;

  int checks = 0;
  int failures = 0;

  int q[$];
  logic [7:0] ea, eb;
  logic [3:0] ecnt;
  logic evld, ec_d, ec_cnt, ec_val;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_bit_gather #(
    .DATA_BITS(8), .LSB_FIRST("true")
  ) dut_a (
    .clk(clk), .reset(rst_n), .cke(cke), .s_data(s_data),
    .s_clear(s_clear), .s_valid(s_valid), .s_last(s_last),
    .m_data(a_data), .m_count(a_cnt), .m_valid(a_val)
  );

  elixirchip_es1_spu_op_bit_gather #(
    .DATA_BITS(8), .LSB_FIRST("false")
  ) dut_b (
    .clk(clk), .reset(rst_n), .cke(cke), .s_data(s_data),
    .s_clear(s_clear), .s_valid(s_valid), .s_last(s_last),
    .m_data(b_data), .m_count(b_cnt), .m_valid(b_val)
  );

  elixirchip_es1_spu_op_bit_gather #(
    .DATA_BITS(1)
  ) dut_c (
    .clk(clk), .reset(rst_n), .cke(cke), .s_data(s_data),
    .s_clear(s_clear), .s_valid(s_valid), .s_last(s_last),
    .m_data(c_data), .m_count(c_cnt), .m_valid(c_val)
  );

  wire [28:0] got = {a_data, a_cnt, a_val, b_data, b_cnt, b_val,
                     c_data, c_cnt, c_val};

  function automatic logic [28:0] exp_vec();
    return {ea, ecnt, evld, eb, ecnt, evld, ec_d, ec_cnt, ec_val};
  endfunction

  task automatic model_reset();
    q.delete();
    ea = '0; eb = '0; ecnt = '0; evld = 1'b0;
    ec_d = 1'b0; ec_cnt = 1'b0; ec_val = 1'b0;
  endtask

  // Word semantics: bits collect in arrival order; the word closes at 8
  // bits or on s_last, then lands LSB-first or MSB-first.
  task automatic model_edge(input logic v, d, l, c, k);
    if (!k) return;
    if (c) begin
      model_reset();
      return;
    end
    if (!v) begin
      evld = 1'b0;
      ec_val = 1'b0;
      return;
    end
    q.push_back(int'(d));
    if (q.size() == 8 || l) begin
      ea = '0;
      eb = '0;
      foreach (q[i]) begin
        ea[i] = q[i][0];
        eb[7-i] = q[i][0];
      end
      ecnt = 4'(q.size());
      evld = 1'b1;
      q.delete();
    end else begin
      evld = 1'b0;
    end
    ec_d = d;
    ec_cnt = 1'b1;
    ec_val = 1'b1;
  endtask

  task automatic step(input logic v, d, l, c, k);
    s_valid = v; s_data = d; s_last = l; s_clear = c; cke = k;
    @(posedge clk);
    model_edge(v, d, l, c, k);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cke = 1'b1; s_data = 1'b1;
    s_clear = 1'b0; s_valid = 1'b1; s_last = 1'b0;
    model_reset();
    #12;
    checks++;
    if (got !== 29'd0) begin
      failures++;
      $display("FAIL reset got=%h exp=0", got);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 1);
    checks++;
    if (got !== exp_vec()) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=%h", got, exp_vec());
    end
  endtask

  task automatic test_pattern();
    logic [7:0] pat;
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      step(1, pat[i], 0, 0, 1);
      checks++;
      if (got !== exp_vec()) begin
        failures++;
        $display("FAIL pattern[%0d] got=%h exp=%h", i, got, exp_vec());
      end
    end
    checks++;
    if ({a_data, b_data, a_cnt, a_val} !== {8'h4D, 8'hB2, 4'd8, 1'b1}) begin
      failures++;
      $display("FAIL pattern_word got=%h %h %0d %b exp=4d b2 8 1",
               a_data, b_data, a_cnt, a_val);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if ({a_val, b_val, a_data} !== {1'b0, 1'b0, 8'h4D}) begin
      failures++;
      $display("FAIL pattern_strobe got=%b %b %h exp=0 0 4d",
               a_val, b_val, a_data);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    step(1, 1, 1, 0, 1);
    checks++;
    if ({a_data, b_data, a_cnt, a_val} !== {8'h07, 8'hE0, 4'd3, 1'b1}) begin
      failures++;
      $display("FAIL short_word got=%h %h %0d %b exp=07 e0 3 1",
               a_data, b_data, a_cnt, a_val);
    end
    for (int i = 0; i < 16; i++) begin
      step(1, (i < 8) ? 1'b1 : 1'($urandom), 0, 0, 1);
      checks++;
      if (got !== exp_vec()) begin
        failures++;
        $display("FAIL b2b[%0d] got=%h exp=%h", i, got, exp_vec());
      end
      if (i == 7) begin
        checks++;
        if ({a_data, b_data, a_cnt, a_val} !== {8'hFF, 8'hFF, 4'd8, 1'b1}) begin
          failures++;
          $display("FAIL ones_word got=%h %h %0d %b exp=ff ff 8 1",
                   a_data, b_data, a_cnt, a_val);
        end
      end
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) step(1, 1'($urandom), 0, 0, 1);
    step(1, 1, 1, 1, 1);
    checks++;
    if ({a_data, a_cnt, a_val, b_data, c_data, c_cnt, c_val} !== 23'd0) begin
      failures++;
      $display("FAIL clear got=%h %0d %b exp=00 0 0", a_data, a_cnt, a_val);
    end
    for (int i = 0; i < 8; i++) begin
      step(1, 1'($urandom), 0, 0, 1);
      checks++;
      if (got !== exp_vec()) begin
        failures++;
        $display("FAIL clear_fresh[%0d] got=%h exp=%h", i, got, exp_vec());
      end
    end
    checks++;
    if ({a_cnt, a_val} !== {4'd8, 1'b1}) begin
      failures++;
      $display("FAIL clear_count got=%0d %b exp=8 1", a_cnt, a_val);
    end
  endtask

  task automatic test_cke();
    for (int i = 0; i < 11; i++) begin
      if (i >= 4 && i < 7)
        step(1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
      else
        step(1, 1'($urandom), 0, 0, 1);
      checks++;
      if (got !== exp_vec()) begin
        failures++;
        $display("FAIL cke[%0d] got=%h exp=%h", i, got, exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom), 1'($urandom), 0, 1'($urandom), 0);
      checks++;
      if ({a_val, a_cnt, got} !== {1'b1, 4'd8, exp_vec()}) begin
        failures++;
        $display("FAIL cke_stretch[%0d] got=%b %0d exp=1 8", i, a_val, a_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) step(1, 1'($urandom), 0, 0, 1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (got !== 29'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", got);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 1);
    checks++;
    if (got !== 29'd0) begin
      failures++;
      $display("FAIL reset_no_word got=%h exp=0", got);
    end
    for (int i = 0; i < 8; i++) begin
      step(1, 1'($urandom), 0, 0, 1);
      checks++;
      if (got !== exp_vec()) begin
        failures++;
        $display("FAIL post_reset[%0d] got=%h exp=%h", i, got, exp_vec());
      end
    end
    checks++;
    if ({a_cnt, a_val} !== {4'd8, 1'b1}) begin
      failures++;
      $display("FAIL post_reset_count got=%0d %b exp=8 1", a_cnt, a_val);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 7) != 0);
      checks++;
      if (got !== exp_vec()) begin
        failures++;
        $display("FAIL random[%0d] got=%h exp=%h", i, got, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_back_to_back();
    test_clear();
    test_cke();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elixirchip_es1_spu_op_bit_gather.md
ELIXIRCHIP_ES1_SPU_OP_BIT_GATHER -- requirements
Module: elixirchip_es1_spu_op_bit_gather

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 36, meaning width of the assembled output word (1 to 64).
REQ-002 The module SHALL have parameter LSB_FIRST, default "true", meaning that the first accepted bit lands in m_data[0]; "false" means it lands in m_data[DATA_BITS-1].
REQ-003 The module SHALL have parameter CLEAR_DATA, default 1'b0, meaning the bit value replicated into m_data on clear.
REQ-004 The module SHALL have parameters DEVICE "RTL", SIMULATION "false" and DEBUG "false", meaning target, sim and debug flags; they have no functional effect.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 cke  input  1  clock enable; all state holds while low.
REQ-008 s_data  input  1  serial input bit.
REQ-009 s_clear  input  1  abort the word in progress and clear the output.
REQ-010 s_valid  input  1  s_data qualifier.
REQ-011 s_last  input  1  with s_valid, marks the final bit of a short word.
REQ-012 m_data  output  DATA_BITS  assembled word.
REQ-013 m_count  output  $clog2(DATA_BITS+1)  number of bits collected in the emitted word (1..DATA_BITS).
REQ-014 m_valid  output  1  single-cycle word-available strobe.

Function
REQ-015 Internal state SHALL be a bit counter cnt (0..DATA_BITS-1) and an assembly register asm of DATA_BITS bits.
REQ-016 A bit SHALL be accepted only on a rising edge where cke=1, s_valid=1 and s_clear=0.
REQ-017 An accepted bit SHALL be written to asm at index cnt (LSB_FIRST="true") or at index DATA_BITS-1-cnt (LSB_FIRST="false").
REQ-018 The word SHALL complete when an accepted bit has cnt==DATA_BITS-1 or s_last=1.
REQ-019 On completion, the same edge SHALL load m_data with asm merged with the current bit, with every unfilled position forced to 0.
REQ-020 On completion, the same edge SHALL set m_count=cnt+1, set m_valid=1 and reset cnt to 0 and asm to 0.
REQ-021 Latency: m_valid SHALL rise exactly 1 cycle after the completing bit is sampled.
REQ-022 Back-to-back words with no idle cycle SHALL be supported with no lost bits.
REQ-023 On a non-completing accept, cnt SHALL increment, m_valid SHALL go to 0 and m_data/m_count SHALL hold.
REQ-024 On an enabled edge with s_valid=0 and s_clear=0, m_valid SHALL go to 0, cnt/asm SHALL hold and m_data/m_count SHALL hold.
REQ-025 s_clear=1 with cke=1 SHALL set cnt=0, asm=0, m_data={DATA_BITS{CLEAR_DATA}}, m_count=0 and m_valid=0.
REQ-026 s_clear SHALL take priority over s_valid and s_last on the same edge; the bit presented on that edge SHALL be discarded.
REQ-027 s_last=1 with s_valid=0 SHALL be ignored.
REQ-028 s_last=1 on the bit where cnt==DATA_BITS-1 SHALL produce one full word with m_count=DATA_BITS.
REQ-029 With cke=0, every register including m_valid SHALL hold; a strobe is therefore stretched while cke is low.
REQ-030 With DATA_BITS=1, every accepted bit SHALL complete a word, with m_count=1.

Reset
REQ-031 While reset=0, cnt, asm, m_data, m_count and m_valid SHALL be 0 asynchronously, independent of clk and cke.
REQ-032 Reset assertion during a partial word SHALL discard that word; no m_valid SHALL follow.
REQ-033 After reset deasserts, the first accepted bit SHALL be treated as bit 0 of a new word.

Verification
REQ-034 With DATA_BITS=8 and LSB_FIRST="true", feed bits 1,0,1,1,0,0,1,0 on consecutive cycles -> one cycle later m_data=8'h4D, m_count=8, m_valid high for exactly 1 cycle.
REQ-035 With LSB_FIRST="false", feed the same sequence -> m_data=8'hB2.
REQ-036 Feed bits 1,1,1 with s_last on the third bit -> m_data=8'h07 and m_count=3; then feed 8 ones back-to-back -> m_data=8'hFF and m_count=8 on consecutive word strobes with no gap.
REQ-037 Feed 5 bits, then assert s_clear together with s_valid -> m_data=8'h00 (CLEAR_DATA=0), m_valid=0; the next 8 bits form a fresh word.
REQ-038 Feed 4 bits, drop cke for 3 cycles while toggling s_valid/s_data, then feed 4 more bits -> word built from the 8 enabled bits only; a strobe occurring while cke=0 holds for the cke-low duration.
REQ-039 Feed 6 bits, pulse reset low asynchronously mid-cycle -> all outputs go to 0 immediately; a subsequent 8-bit feed produces the correct word with m_count=8.
